// File: rtl/dbus_bridge_if.sv
// Signal bundle between the LSU, the data-bus bridge and the external bus.
// The master modport is the bridge's view; slave is the surrounding environment's.
interface dbus_bridge_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_a_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic        flush_i;
  logic [31:0] mem_data_o;
  logic        stall_req_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  logic        bus_err_o;
  logic        bus_tmo_o;

  modport master (
    input  mem_ce_i, mem_we_i, mem_a_i, mem_sel_i, mem_data_i, flush_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output mem_data_o, stall_req_o, bus_req_o, bus_we_o, bus_addr_o,
    output bus_sel_o, bus_wdata_o, bus_err_o, bus_tmo_o
  );

  modport slave (
    output mem_ce_i, mem_we_i, mem_a_i, mem_sel_i, mem_data_i, flush_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  mem_data_o, stall_req_o, bus_req_o, bus_we_o, bus_addr_o,
    input  bus_sel_o, bus_wdata_o, bus_err_o, bus_tmo_o
  );
endinterface

// File: rtl/dbus_bridge.sv
// LSU-to-bus bridge: turns a single-cycle LSU access into a req/gnt/rvalid
// transaction, stalling the pipeline and reporting slave errors and timeouts.
module dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rs_n_i,
  dbus_bridge_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r, state_s;
  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  sel_r;
  logic [31:0] wdata_r;
  logic [7:0]  cnt_r, cnt_s;
  logic        flushed_r, flushed_s;
  logic [31:0] data_r, data_s;
  logic        err_r, err_s;
  logic        tmo_r, tmo_s;
  logic        issue_s;

  assign issue_s = bus.mem_ce_i & ~bus.flush_i;

  // Stall is combinational on the IDLE term so the LSU holds in the access cycle.
  assign bus.stall_req_o = ((state_r == ST_IDLE) & issue_s & rs_n_i) |
                           (state_r == ST_REQ) | (state_r == ST_WAIT);
  assign bus.bus_req_o   = (state_r == ST_REQ);
  assign bus.bus_we_o    = we_r;
  assign bus.bus_addr_o  = addr_r;
  assign bus.bus_sel_o   = sel_r;
  assign bus.bus_wdata_o = wdata_r;
  assign bus.mem_data_o  = data_r;
  assign bus.bus_err_o   = err_r;
  assign bus.bus_tmo_o   = tmo_r;

  // Next state, timeout counter, flush flag and the DONE-cycle results.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    flushed_s = flushed_r;
    data_s    = 32'h0000_0000;
    err_s     = 1'b0;
    tmo_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_s   = ST_REQ;
          cnt_s     = 8'd0;
          flushed_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        flushed_s = flushed_r | bus.flush_i;
        if (bus.bus_gnt_i) begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r + 8'd1;
        end else if (cnt_r >= TMO_LAST) begin
          state_s = ST_DONE;
          err_s   = ~flushed_s;
          tmo_s   = ~flushed_s;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_WAIT: begin
        flushed_s = flushed_r | bus.flush_i;
        if (bus.bus_rvalid_i) begin
          state_s = ST_DONE;
          err_s   = bus.bus_err_i & ~flushed_s;
          if (~we_r & ~bus.bus_err_i & ~flushed_s) begin
            data_s = bus.bus_rdata_i;
          end else begin
            data_s = 32'h0000_0000;
          end
        end else if (cnt_r >= TMO_LAST) begin
          state_s = ST_DONE;
          err_s   = ~flushed_s;
          tmo_s   = ~flushed_s;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and result registers; results only live for the DONE cycle.
  always_ff @(posedge clk_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      flushed_r <= 1'b0;
      data_r    <= 32'h0000_0000;
      err_r     <= 1'b0;
      tmo_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      flushed_r <= flushed_s;
      data_r    <= data_s;
      err_r     <= err_s;
      tmo_r     <= tmo_s;
    end
  end

  // Request fields are captured once at issue and held until the next access.
  always_ff @(posedge clk_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      sel_r   <= 4'h0;
      wdata_r <= 32'h0000_0000;
    end else if ((state_r == ST_IDLE) && issue_s) begin
      we_r    <= bus.mem_we_i;
      addr_r  <= {bus.mem_a_i[31:2], 2'b00};
      sel_r   <= bus.mem_sel_i;
      wdata_r <= bus.mem_data_i;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      sel_r   <= sel_r;
      wdata_r <= wdata_r;
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed self-checking bench for dbus_bridge (timeout set to 8 cycles):
// zero-wait load, waited store, slave error, timeout, flush and async reset.
module tb_dbus_bridge;

  logic clk = 1'b0;
  logic rs_n;
  always #5 clk = ~clk;

  dbus_bridge_if bif();

  dbus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i  (clk),
    .rs_n_i (rs_n),
    .bus    (bif.master)
  );

  int checks_cnt = 0;
  int fail_cnt   = 0;

  int          r_stall, r_req, r_err_pulses, r_tmo_pulses;
  bit          r_done, r_stable;
  logic        r_we, r_post_stall;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.mem_ce_i     = 1'b0;
    bif.mem_we_i     = 1'b0;
    bif.mem_a_i      = 32'h0;
    bif.mem_sel_i    = 4'h0;
    bif.mem_data_i   = 32'h0;
    bif.flush_i      = 1'b0;
    bif.bus_gnt_i    = 1'b0;
    bif.bus_rvalid_i = 1'b0;
    bif.bus_rdata_i  = 32'h0;
    bif.bus_err_i    = 1'b0;
  endtask

  // gnt_at: REQ cycle carrying grant (0 = never); rv_at / flush_w: WAIT cycle index.
  task automatic run_access(input logic we, input logic [31:0] a, input logic [3:0] sel,
                            input logic [31:0] d, input int gnt_at, input int rv_at,
                            input logic [31:0] rdata, input logic err, input int flush_w);
    int req_cyc;
    int wait_cyc;
    bit granted;
    r_stall = 0; r_req = 0; r_err_pulses = 0; r_tmo_pulses = 0;
    r_done = 1'b0; r_stable = 1'b1; r_data = 32'hFFFF_FFFF;
    req_cyc = 0; wait_cyc = 0; granted = 1'b0;
    @(negedge clk);
    bif.mem_ce_i = 1'b1; bif.mem_we_i = we; bif.mem_a_i = a;
    bif.mem_sel_i = sel; bif.mem_data_i = d; bif.bus_rdata_i = rdata;
    for (int c = 0; c < 40 && !r_done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      r_err_pulses += int'(bif.bus_err_o);
      r_tmo_pulses += int'(bif.bus_tmo_o);
      bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_err_i = 1'b0; bif.flush_i = 1'b0;
      if (bif.stall_req_o) begin
        r_stall++;
        if (bif.bus_req_o) begin
          req_cyc++;
          r_req = req_cyc;
          if (req_cyc == 1) begin
            r_we = bif.bus_we_o; r_addr = bif.bus_addr_o;
            r_sel = bif.bus_sel_o; r_wdata = bif.bus_wdata_o;
          end else if ({bif.bus_we_o, bif.bus_addr_o, bif.bus_sel_o, bif.bus_wdata_o}
                       !== {r_we, r_addr, r_sel, r_wdata}) begin
            r_stable = 1'b0;
          end
          if (req_cyc == gnt_at) begin
            bif.bus_gnt_i = 1'b1;
            granted = 1'b1;
          end
        end else if (granted) begin
          wait_cyc++;
          if (wait_cyc == rv_at) begin
            bif.bus_rvalid_i = 1'b1;
            bif.bus_err_i = err;
          end
          if (wait_cyc == flush_w) bif.flush_i = 1'b1;
        end
      end else if (c > 0) begin
        r_done = 1'b1;
        r_data = bif.mem_data_o;
      end
    end
    @(negedge clk);
    bif.mem_ce_i = 1'b0;
    #1;
    r_err_pulses += int'(bif.bus_err_o);
    r_tmo_pulses += int'(bif.bus_tmo_o);
    r_post_stall = bif.stall_req_o;
  endtask

  initial begin
    idle_inputs();
    rs_n = 1'b0;
    #12;
    chk("rst_req",   {31'd0, bif.bus_req_o},   32'd0);
    chk("rst_stall", {31'd0, bif.stall_req_o}, 32'd0);
    chk("rst_addr",  bif.bus_addr_o,           32'h0);
    chk("rst_wdata", bif.bus_wdata_o,          32'h0);
    chk("rst_misc",  {27'd0, bif.bus_we_o, bif.bus_sel_o}, 32'd0);
    chk("rst_out",   {bif.mem_data_o[29:0], bif.bus_err_o, bif.bus_tmo_o}, 32'd0);
    @(negedge clk);
    rs_n = 1'b1;

    // Zero-wait load
    run_access(1'b0, 32'h0000_1004, 4'hF, 32'h0, 1, 1, 32'hDEAD_BEEF, 1'b0, 0);
    chk("ld_done",  {31'd0, r_done}, 32'd1);
    chk("ld_stall", r_stall, 32'd3);
    chk("ld_addr",  r_addr, 32'h0000_1004);
    chk("ld_data",  r_data, 32'hDEAD_BEEF);
    chk("ld_err",   r_err_pulses, 32'd0);

    // Store, grant on 3rd REQ cycle, response on 3rd WAIT cycle
    run_access(1'b1, 32'h0000_2002, 4'b1100, 32'hABCD_ABCD, 3, 3, 32'h55AA_55AA, 1'b0, 0);
    chk("st_stall",  r_stall, 32'd7);
    chk("st_addr",   r_addr, 32'h0000_2000);
    chk("st_sel",    {28'd0, r_sel}, 32'h0000_000C);
    chk("st_wdata",  r_wdata, 32'hABCD_ABCD);
    chk("st_we",     {31'd0, r_we}, 32'd1);
    chk("st_stable", {31'd0, r_stable}, 32'd1);
    chk("st_data",   r_data, 32'h0);
    chk("st_err",    r_err_pulses, 32'd0);

    // Slave error on a load
    run_access(1'b0, 32'h0000_3000, 4'hF, 32'h0, 1, 1, 32'hCAFE_F00D, 1'b1, 0);
    chk("se_err",  r_err_pulses, 32'd1);
    chk("se_tmo",  r_tmo_pulses, 32'd0);
    chk("se_data", r_data, 32'h0);
    chk("se_post", {31'd0, r_post_stall}, 32'd0);

    // Timeout: grant never given
    run_access(1'b0, 32'h0000_4000, 4'hF, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 0);
    chk("to_done",  {31'd0, r_done}, 32'd1);
    chk("to_req",   r_req, 32'd8);
    chk("to_stall", r_stall, 32'd9);
    chk("to_err",   r_err_pulses, 32'd1);
    chk("to_tmo",   r_tmo_pulses, 32'd1);
    chk("to_rdata", r_data, 32'h0);
    @(negedge clk);
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'h7777_7777;
    @(negedge clk);
    bif.bus_rvalid_i = 1'b0;
    #1;
    chk("late_rv_out", {bif.stall_req_o, bif.bus_req_o, bif.bus_err_o, bif.bus_tmo_o}, 32'd0);
    chk("late_rv_data", bif.mem_data_o, 32'h0);

    // Flush during WAIT of a load
    run_access(1'b0, 32'h0000_5008, 4'hF, 32'h0, 1, 2, 32'h1234_5678, 1'b0, 1);
    chk("fl_done",  {31'd0, r_done}, 32'd1);
    chk("fl_stall", r_stall, 32'd4);
    chk("fl_data",  r_data, 32'h0);
    chk("fl_err",   r_err_pulses, 32'd0);

    // Flush held with ce in IDLE
    @(negedge clk);
    bif.mem_ce_i = 1'b1;
    bif.flush_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fi_out", {30'd0, bif.stall_req_o, bif.bus_req_o}, 32'd0);
      @(negedge clk);
    end
    bif.mem_ce_i = 1'b0;
    bif.flush_i  = 1'b0;

    // Async reset mid-REQ
    @(negedge clk);
    bif.mem_ce_i = 1'b1; bif.mem_we_i = 1'b0; bif.mem_a_i = 32'h0000_6000; bif.mem_sel_i = 4'hF;
    @(negedge clk);
    #1;
    chk("ar_in_req", {31'd0, bif.bus_req_o}, 32'd1);
    #1;
    rs_n = 1'b0;
    #1;
    chk("ar_req",   {31'd0, bif.bus_req_o},   32'd0);
    chk("ar_stall", {31'd0, bif.stall_req_o}, 32'd0);
    @(negedge clk);
    bif.mem_ce_i = 1'b0;
    rs_n = 1'b1;
    run_access(1'b0, 32'h0000_1004, 4'hF, 32'h0, 1, 1, 32'hDEAD_BEEF, 1'b0, 0);
    chk("ar_ld_stall", r_stall, 32'd3);
    chk("ar_ld_addr",  r_addr, 32'h0000_1004);
    chk("ar_ld_data",  r_data, 32'hDEAD_BEEF);
    chk("ar_ld_err",   r_err_pulses, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-bus bridge between the LSU (`mem`) stage and the external data memory/peripheral bus. It accepts the LSU's combinational single-cycle access (`ce/we/addr/sel/data`) and converts it into a request/grant/response transaction. It stalls the pipeline until the response arrives, then returns read data to the LSU. It also detects bus errors and timeouts and reports them to the control unit.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum number of cycles spent in REQ+WAIT before the access is aborted as a timeout; legal range 2..255.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rs_n_i`  in  1  reset, asynchronous, active-low.
- `mem_ce_i`  in  1  access request from LSU (level).
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_a_i`  in  32  byte address.
- `mem_sel_i`  in  4  byte-lane enables.
- `mem_data_i`  in  32  store data, already lane-replicated by the LSU.
- `flush_i`  in  1  pipeline flush from control (exception/redirect).
- `mem_data_o`  out  32  load data returned to LSU.
- `stall_req_o`  out  1  stall request to control.
- `bus_req_o`  out  1  request valid.
- `bus_we_o`  out  1  write strobe.
- `bus_addr_o`  out  32  address, word-aligned: `{a[31:2],2'b00}`.
- `bus_sel_o`  out  4  byte enables.
- `bus_wdata_o`  out  32  write data.
- `bus_gnt_i`  in  1  request accepted.
- `bus_rvalid_i`  in  1  response valid; required for both loads and stores.
- `bus_rdata_i`  in  32  read data, valid with `bus_rvalid_i`.
- `bus_err_i`  in  1  slave error, sampled with `bus_rvalid_i`.
- `bus_err_o`  out  1  one-cycle pulse on error or timeout of a non-flushed access.
- `bus_tmo_o`  out  1  one-cycle pulse, qualifies `bus_err_o` as a timeout.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE. Reset state is IDLE.
- **IDLE:**
  - If `mem_ce_i & ~flush_i`, capture `we`, `addr`, `sel` and `wdata` into request registers, clear the timeout counter, clear the flush flag, and go to REQ.
  - Otherwise stay in IDLE.
  - `flush_i` in IDLE suppresses issue of a new access.
- **REQ:**
  - Drive `bus_req_o=1` together with the registered fields.
  - On `bus_gnt_i`, go to WAIT.
  - Fields are held stable until grant.
- **WAIT:**
  - `bus_req_o=0`.
  - On `bus_rvalid_i`: if the access is a load, capture `bus_rdata_i` into `rdata_q`; capture `bus_err_i` into `err_q`; go to DONE.
- **Timeout:**
  - The counter increments in every REQ/WAIT cycle. When it reaches `TIMEOUT_CYCLES-1` without progress, go to DONE with `err_q=1` and `tmo_q=1`.
  - `bus_req_o` is withdrawn in DONE. Withdrawal is the only case in which req drops without grant.
- **DONE:**
  - `stall_req_o=0`.
  - `mem_data_o = rdata_q` for a non-flushed load with `err_q=0`; otherwise 0.
  - `bus_err_o = err_q & ~flushed`. `bus_tmo_o = tmo_q & ~flushed`.
  - Unconditionally go to IDLE.
- **Flush during REQ/WAIT:**
  - Set the `flushed` flag.
  - The bus transaction is not aborted; it completes normally or times out.
  - The DONE results are then discarded: `mem_data_o=0` and no error pulse.
- Late `bus_rvalid_i` after a timeout is ignored in IDLE.
- `bus_rvalid_i` outside WAIT is ignored.
- `bus_gnt_i` outside REQ is ignored.

## Timing
- `stall_req_o` = `(IDLE & mem_ce_i & ~flush_i) | REQ | WAIT`. It is combinational on the IDLE term so the LSU holds in the same cycle the access appears.
- Minimum load/store latency is 4 cycles:
  - IDLE (stall)
  - REQ with grant the same cycle
  - WAIT with rvalid the same cycle
  - DONE (stall low; the pipeline advances at the end of this cycle)
- Each cycle of grant delay or response delay adds 1 cycle.
- DONE always returns to IDLE, so back-to-back accesses have a 4-cycle minimum spacing; an access is never re-issued.
- Reset values, applied asynchronously:
  - state IDLE
  - `bus_req_o=0`, `bus_we_o=0`, `bus_addr_o=0`, `bus_sel_o=0`, `bus_wdata_o=0`
  - `mem_data_o=0`, `bus_err_o=0`, `bus_tmo_o=0`
  - `stall_req_o=0` (the IDLE term is gated by reset)
  - all internal registers 0
- Reset mid-transaction returns immediately to IDLE and drops `bus_req_o`. Responses in flight are ignored.

## Test plan
- **Load, zero-wait:** `ce=1`, `we=0`, `a=0x1004`, `sel=4'b1111`; `gnt` and `rvalid` each asserted on the first cycle offered; `rdata=0xDEADBEEF`. Required: `stall` high for 3 cycles; `bus_addr_o=0x1004`; `mem_data_o=0xDEADBEEF` in DONE; no error pulse.
- **Store with waits:** `we=1`, `a=0x2002`, `sel=4'b1100`, `data=0xABCDABCD`; `gnt` after 2 cycles, `rvalid` after 3 more. Required: req fields stable during REQ; `bus_addr_o=0x2000`; stall lasts 7 cycles; `mem_data_o=0`.
- **Slave error:** load with `rvalid` and `bus_err_i` both 1. Required: one-cycle `bus_err_o=1`, `bus_tmo_o=0`, `mem_data_o=0`.
- **Timeout:** `TIMEOUT_CYCLES=8`, `gnt` never asserted. Required:
  - DONE is reached after 8 stall cycles in REQ;
  - `bus_req_o` drops;
  - `bus_err_o=1` and `bus_tmo_o=1` for one cycle;
  - a later `rvalid` pulse is ignored.
- **Flush:** `flush_i` pulsed during WAIT of a load with `rdata=0x12345678`. Required: the transaction completes, `mem_data_o=0`, no error pulse. Separately, `flush_i` held together with `ce` in IDLE issues no `bus_req_o` and keeps `stall_req_o=0`.
- **Async reset:** `rs_n_i` low mid-REQ. Required: `bus_req_o` and `stall_req_o` fall without waiting for a clock edge; after release the FSM is in IDLE and the next access behaves as in the zero-wait load case.
